// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider family.
package div_pkg;

  localparam int DIV_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider4_sub_stage.sv
// Combinational N-bit subtractor a - b - bin with borrow-out; the single
// subtract stage reused by every iteration of the sequential divider.
module sub_stage
  import div_pkg::*;
#(
  parameter int N = DIV_W_DEFAULT + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] full;

  always_comb begin
    full = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
    diff = full[N-1:0];
    bout = full[N];
  end

endmodule

// File: rtl/seq_divider4.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Optional divide-by-zero fast path and err flag enabled by SEQ_DIV_ZERO_CHK_EN.
module seq_divider4
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIV_ZERO_CHK_EN
  ,
  output logic             err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t state, state_next;

  logic [WIDTH-1:0] q_reg, r_reg, d_reg;
  logic [CW-1:0]    count;
  logic             load, step, zero_div;
  logic [WIDTH:0]   trial_a, trial_b, trial_diff;
  logic             trial_borrow, qbit;

  assign trial_a = {r_reg, q_reg[WIDTH-1]};
  assign trial_b = {1'b0, d_reg};

  sub_stage #(.N(WIDTH + 1)) u_sub (
    .a    (trial_a),
    .b    (trial_b),
    .bin  (1'b0),
    .diff (trial_diff),
    .bout (trial_borrow)
  );

  // A non-borrowing trial always has a zero top bit, so folding it in is free.
  assign qbit = ~(trial_borrow | trial_diff[WIDTH]);

`ifdef SEQ_DIV_ZERO_CHK_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (count == CW'(1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '0;
      r_reg <= '0;
      d_reg <= '0;
      count <= '0;
    end else if (load) begin
      d_reg <= divisor;
      count <= CW'(WIDTH);
      if (zero_div) begin
        q_reg <= '1;
        r_reg <= dividend;
      end else begin
        q_reg <= dividend;
        r_reg <= '0;
      end
    end else if (step) begin
      // Restore path reuses the shifted partial remainder held in trial_a.
      q_reg <= {q_reg[WIDTH-2:0], qbit};
      r_reg <= qbit ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
      count <= count - CW'(1);
    end
  end

`ifdef SEQ_DIV_ZERO_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    err <= 1'b0;
    else if (load) err <= zero_div;
  end
`endif

  assign quotient  = q_reg;
  assign remainder = r_reg;

endmodule

// File: tb/tb_seq_divider4.sv
// Randomized scoreboard bench for seq_divider4: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider4;

  localparam int W = 4;
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
`ifdef SEQ_DIV_ZERO_CHK_EN
  logic         err;
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    int           due;
    int           busyCycles;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  int           nTests = 0;
  int           nFail = 0;
  int           ncyc = 0;
  int           busyRun = 0;
  logic [W-1:0] lastQ = '0;
  logic [W-1:0] lastR = '0;

  seq_divider4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQ_DIV_ZERO_CHK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, ncyc);
    end
  endtask

  // Reference: plain integer division, with the all-ones/dividend rule for zero divisors.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int issued);
    exp_t m;
    if (b == 0) begin
      m.q = ONES;
      m.r = a;
    end else begin
      m.q = W'(int'(a) / int'(b));
      m.r = W'(int'(a) % int'(b));
    end
    m.e          = ZCHK && (b == 0);
    m.due        = (ZCHK && b == 0) ? issued + 1 : issued + W + 1;
    m.busyCycles = (ZCHK && b == 0) ? 0 : W;
    return m;
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      if (busy) busyRun++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_done", done, 0);
        end else begin
          cur = sb.pop_front();
          checkOutput("quotient", quotient, cur.q);
          checkOutput("remainder", remainder, cur.r);
          checkOutput("done_cycle", ncyc, cur.due);
          checkOutput("busy_cycles", busyRun, cur.busyCycles);
`ifdef SEQ_DIV_ZERO_CHK_EN
          checkOutput("err", err, cur.e);
`endif
          lastQ = cur.q;
          lastR = cur.r;
        end
        busyRun = 0;
      end
    end
  end

  // Issues one single-cycle start while the DUT is idle, then scrambles the operands.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); #1;
    checkOutput("held_quotient", quotient, lastQ);
    checkOutput("held_remainder", remainder, lastR);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b, ncyc));
    @(negedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); #2;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    logic [W-1:0] a, b;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
`ifdef SEQ_DIV_ZERO_CHK_EN
    checkOutput("reset_err", err, 0);
`endif
    rst_n = 1'b1;

    applyStimulus(4'd13, 4'd3);  waitIdle();
    applyStimulus(4'd15, 4'd1);  waitIdle();
    applyStimulus(4'd7,  4'd9);  waitIdle();
    applyStimulus(4'd0,  4'd5);  waitIdle();
    applyStimulus(4'd15, 4'd15); waitIdle();
    applyStimulus(4'd6,  4'd0);  waitIdle();

    // A start pulse during RUN must be ignored: no second done, result unchanged.
    @(negedge clk); #1;
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    sb.push_back(model(4'd13, 4'd3, ncyc));
    @(negedge clk); #1; start = 1'b0;
    @(negedge clk); #1; dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    waitIdle();
    repeat (6) @(negedge clk);

    // Reset in the third RUN cycle abandons the operation.
    @(negedge clk); #1;
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    sb.push_back(model(4'd13, 4'd3, ncyc));
    @(negedge clk); #1; start = 1'b0;
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b0;
    sb.delete();
    busyRun = 0;
    lastQ = '0;
    lastR = '0;
    @(negedge clk); #1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_quotient", quotient, 0);
    checkOutput("midreset_remainder", remainder, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    applyStimulus(4'd10, 4'd4); waitIdle();

    // start held high: second op accepted W+2 cycles after the first.
    @(negedge clk); #1;
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    sb.push_back(model(4'd12, 4'd5, ncyc));
    @(negedge clk); #1;
    dividend = W'($urandom); divisor = W'($urandom);
    repeat (W + 1) @(negedge clk);
    #1;
    dividend = 4'd9; divisor = 4'd3;
    sb.push_back(model(4'd9, 4'd3, ncyc));
    @(negedge clk); #1; start = 1'b0;
    waitIdle();

    for (int i = 0; i < 30; i++) begin
      a = W'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(a, b);
      waitIdle();
    end

    repeat (8) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
